// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shared data-memory port-B arbiter.
// Round-robin grant among NUM_REQ requesters, locked bursts capped at
// MAX_BURST transfers, read responses routed back after a fixed RAM
// latency, and RAM writes suppressed while the CPU is halted.
// Build option DMEM_ARB_FIXED_PRIO_EN: idle grant becomes fixed priority
// (lowest index wins) and the round-robin pointer is removed.
module dmem_port_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       halt,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_wr,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic                       mem_rden,
    output logic                       mem_wren,
    input  logic [DATA_W-1:0]          mem_q
);

    localparam int         ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_owner;
    logic [ID_W-1:0]   w_owner_nxt;
    logic [7:0]        r_burst_cnt;
    logic [7:0]        w_burst_nxt;
    logic              w_gnt_vld;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_acc_rd;
    logic              w_acc_lock;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [ID_W-1:0]   r_pipe_id [RD_LAT];

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_cand_id [NUM_REQ];
    logic [NUM_REQ-1:0] w_rot;

    // Candidate k is the requester k places after the round-robin pointer.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(r_rr_ptr) + k >= NUM_REQ) begin
                w_cand_id[k] = ID_W'(int'(r_rr_ptr) + k - NUM_REQ);
            end else begin
                w_cand_id[k] = ID_W'(int'(r_rr_ptr) + k);
            end
            w_rot[k] = req_valid[w_cand_id[k]];
        end
    end
`endif

    // Grant selection: owner only while locked, otherwise search for a valid requester.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        if (r_state == ST_LOCKED) begin
            w_gnt_vld = req_valid[r_owner];
            w_gnt_id  = r_owner;
        end else begin
            // Scan downward so the closest candidate is the one left standing.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                w_gnt_id  = req_valid[k] ? ID_W'(k) : w_gnt_id;
                w_gnt_vld = w_gnt_vld | req_valid[k];
`else
                w_gnt_id  = w_rot[k] ? w_cand_id[k] : w_gnt_id;
                w_gnt_vld = w_gnt_vld | w_rot[k];
`endif
            end
        end
    end

    assign w_acc_rd   = w_gnt_vld & ~req_wr[w_gnt_id];
    assign w_acc_lock = w_gnt_vld & req_lock[w_gnt_id];

    // Drive the RAM port and ready from the granted requester's slices.
    always_comb begin
        req_ready = '0;
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        if (w_gnt_vld) begin
            req_ready[w_gnt_id] = 1'b1;
            mem_rden = ~req_wr[w_gnt_id];
            // A halted CPU still sees the handshake, but the RAM stays untouched.
            mem_wren = req_wr[w_gnt_id] & ~halt;
            mem_addr = req_addr[int'(w_gnt_id)*ADDR_W +: ADDR_W];
            mem_data = req_wdata[int'(w_gnt_id)*DATA_W +: DATA_W];
        end else begin
            req_ready = '0;
        end
    end

    // Lock/burst state machine next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_acc_lock) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_gnt_id;
                    w_burst_nxt = 8'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_gnt_vld) begin
                    if (w_acc_lock && (r_burst_cnt < BURST_LAST)) begin
                        w_burst_nxt = r_burst_cnt + 8'd1;
                    end else begin
                        // Unlock requested or burst cap reached: give others a turn.
                        w_state_nxt = ST_IDLE;
                        w_burst_nxt = 8'd0;
                    end
                end else if (!req_lock[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                    w_burst_nxt = 8'd0;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = '0;
                w_burst_nxt = 8'd0;
            end
        endcase
    end

    // State, owner and burst counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_burst_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Round-robin pointer moves just past whoever was last served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_rr_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`endif

    // Read-tag pipeline tracking which requester owns each in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_pipe_id[k] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_acc_rd;
            r_pipe_id[0]  <= w_gnt_id;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_id[k]  <= r_pipe_id[k-1];
            end
        end
    end

    // Route RAM output to the tagged requester when its read matures.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (r_pipe_vld[RD_LAT-1]) begin
            rsp_valid[r_pipe_id[RD_LAT-1]] = 1'b1;
            rsp_rdata = mem_q;
        end else begin
            rsp_rdata = '0;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level reference model of the
// arbiter (grant rule, lock ownership, expected response queue, shadow RAM).
module tb_dmem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int RL = 2;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            halt;
    logic [N-1:0]    req_valid, req_wr, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, mem_data, mem_q;
    logic [AW-1:0]   mem_addr;
    logic            mem_rden, mem_wren;

    int n_total = 0;
    int n_bad   = 0;

    dmem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .req_valid(req_valid), .req_wr(req_wr), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Environment RAM with RL-cycle read latency.
    logic [DW-1:0] env_ram [0:(1<<AW)-1];
    logic [DW-1:0] env_q   [0:RL-1];
    assign mem_q = env_q[RL-1];
    always @(posedge clk) begin
        if (mem_wren) env_ram[mem_addr] <= mem_data;
        env_q[0] <= mem_rden ? env_ram[mem_addr] : 16'h0000;
        for (int k = 1; k < RL; k++) env_q[k] <= env_q[k-1];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int m_next  = 0;
    int m_owner = -1;
    int m_taken = 0;
    int cyc     = 0;
    int q_due[$];
    int q_id[$];
    logic [DW-1:0] q_dat[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (req_valid[i]) return i;
`else
        for (int s = 0; s < N; s++) begin
            int c = (m_next + s) % N;
            if (req_valid[c]) return c;
        end
`endif
        return -1;
    endfunction

    // Per-cycle comparison of every output against the model, then model advance.
    always @(negedge clk) begin : mon
        int g;
        logic [N-1:0]  e_rdy, e_rv;
        logic [DW-1:0] e_rd;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_data;
        if (!rst_n) begin
            m_next = 0; m_owner = -1; m_taken = 0;
            q_due.delete(); q_id.delete(); q_dat.delete();
            chk_eq("rst_ready", req_ready, 0);
            chk_eq("rst_rsp_valid", rsp_valid, 0);
            chk_eq("rst_rsp_rdata", rsp_rdata, 0);
            chk_eq("rst_mem", {mem_rden, mem_wren, mem_addr, mem_data}, 0);
        end else begin
            g = model_grant();
            e_rdy = 0; g_addr = 0; g_data = 0;
            if (g >= 0) begin
                e_rdy  = 2'b01 << g;
                g_addr = req_addr[g*AW +: AW];
                g_data = req_wdata[g*DW +: DW];
            end
            e_rv = 0; e_rd = 0;
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                e_rv = 2'b01 << q_id[0];
                e_rd = q_dat[0];
                void'(q_due.pop_front()); void'(q_id.pop_front()); void'(q_dat.pop_front());
            end
            chk_eq("ready", req_ready, e_rdy);
            chk_eq("rden", mem_rden, (g >= 0) && !req_wr[g]);
            chk_eq("wren", mem_wren, (g >= 0) && req_wr[g] && !halt);
            chk_eq("addr", mem_addr, g_addr);
            chk_eq("wdata", mem_data, (g >= 0) ? g_data : 16'h0000);
            chk_eq("rsp_valid", rsp_valid, e_rv);
            chk_eq("rsp_rdata", rsp_rdata, e_rd);
            if (g >= 0) begin
                if (req_wr[g]) begin
                    if (!halt) ref_mem[g_addr] = g_data;
                end else begin
                    q_due.push_back(cyc + RL); q_id.push_back(g); q_dat.push_back(ref_mem[g_addr]);
                end
                m_next = (g + 1) % N;
                if (m_owner < 0) begin
                    if (req_lock[g]) begin m_owner = g; m_taken = 1; end
                end else begin
                    m_taken++;
                    if (!req_lock[g] || m_taken == MB) m_owner = -1;
                end
            end else if (m_owner >= 0 && !req_lock[m_owner]) begin
                m_owner = -1;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_all();
        req_valid = '0; req_wr = '0; req_lock = '0; halt = 1'b0;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v; req_wr[i] = w; req_lock[i] = l;
        req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin env_ram[a] = 16'h0000; ref_mem[a] = 16'h0000; end
        for (int k = 0; k < RL; k++) env_q[k] = 16'h0000;
        rst_n = 1'b0; idle_all(); req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset, then round-robin alternation.
        @(negedge clk);
        chk_eq("idle_ready", req_ready, 2'b00);
        step(); set_req(0, 1'b1, 1'b0, 1'b0, 11'h000, 16'h0); set_req(1, 1'b1, 1'b0, 1'b0, 11'h000, 16'h0);
        @(negedge clk); chk_eq("rr_first", req_ready, 2'b01);
        step(); @(negedge clk); chk_eq("rr_second", req_ready, 2'b10);

        // Write from req0, read back through req1.
        step(); idle_all(); set_req(0, 1'b1, 1'b1, 1'b0, 11'h010, 16'hABCD);
        @(negedge clk); chk_eq("wr_wren", mem_wren, 1'b1);
        step(); idle_all(); set_req(1, 1'b1, 1'b0, 1'b0, 11'h010, 16'h0);
        @(negedge clk); chk_eq("rd_ready", req_ready, 2'b10);
        step(); idle_all();
        @(negedge clk); repeat (RL - 1) @(negedge clk);
        chk_eq("rd_rsp_valid", rsp_valid, 2'b10);
        chk_eq("rd_rsp_rdata", rsp_rdata, 16'hABCD);

        // Locked burst by req1 is capped at MB grants while req0 waits.
        step(); idle_all(); set_req(0, 1'b1, 1'b0, 1'b0, 11'h001, 16'h0);
        step(); set_req(1, 1'b1, 1'b0, 1'b1, 11'h002, 16'h0);
        for (int i = 0; i <= MB; i++) begin
            @(negedge clk);
            chk_eq($sformatf("burst_%0d", i), req_ready, (i < MB) ? 2'b10 : 2'b01);
            step();
        end
        idle_all();

        // Halted write completes handshake but leaves RAM untouched.
        halt = 1'b1; set_req(0, 1'b1, 1'b1, 1'b0, 11'h020, 16'h5555);
        @(negedge clk);
        chk_eq("halt_ready", req_ready, 2'b01);
        chk_eq("halt_wren", mem_wren, 1'b0);
        step(); idle_all(); set_req(0, 1'b1, 1'b0, 1'b0, 11'h020, 16'h0);
        step(); idle_all();
        @(negedge clk); repeat (RL - 1) @(negedge clk);
        chk_eq("halt_rsp_valid", rsp_valid, 2'b01);
        chk_eq("halt_rsp_rdata", rsp_rdata, 16'h0000);

        // Randomized traffic in three flavours: light locking, heavy locking, frequent halt.
        for (int c = 0; c < 900; c++) begin
            step();
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        (c >= 300 && c < 600) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0),
                        AW'($urandom_range(0, 15)), DW'($urandom));
            halt = (c >= 600) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        end
        step(); idle_all();
        repeat (RL + 3) step();

        // Reset while a read is in flight drops its response and rewinds the pointer.
        set_req(0, 1'b1, 1'b0, 1'b0, 11'h001, 16'h0);
        @(negedge clk); chk_eq("pre_rst_ready", req_ready, 2'b01);
        step(); idle_all(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        for (int i = 0; i < RL + 2; i++) begin
            @(negedge clk); chk_eq("post_rst_rsp", rsp_valid, 2'b00);
            step();
        end
        set_req(0, 1'b1, 1'b0, 1'b0, 11'h003, 16'h0); set_req(1, 1'b1, 1'b0, 1'b0, 11'h004, 16'h0);
        @(negedge clk); chk_eq("post_rst_grant", req_ready, 2'b01);

`ifdef DMEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk); chk_eq("fixed_prio", req_ready, 2'b01);
        end
`endif
        step(); idle_all();
        repeat (RL + 3) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
